// File: rtl/writeback_regfile_pkg.sv
// Shared widths and fixed register indices for the write-back register file.
package writeback_regfile_pkg;
    localparam int DATA_W           = 32;
    localparam int IDX_W            = 5;
    localparam int REG_ZERO         = 0;
    localparam int DEFAULT_LINK_REG = 31;
endpackage

// File: rtl/writeback_regfile_if.sv
// Write-back commit and decode-read signals between the pipeline and the register file.
interface writeback_regfile_if;
    import writeback_regfile_pkg::*;

    logic              reg_write_W;
    logic              mem_to_reg_W;
    logic              jump_W;
    logic [DATA_W-1:0] read_data_W;
    logic [DATA_W-1:0] alu_out_W;
    logic [DATA_W-1:0] pc_plus1_W;
    logic [IDX_W-1:0]  write_reg_W;
    logic [IDX_W-1:0]  rs_D;
    logic [IDX_W-1:0]  rt_D;
    logic [DATA_W-1:0] rd1_D;
    logic [DATA_W-1:0] rd2_D;
    logic [DATA_W-1:0] result_W;
    logic              wr_en_eff_W;
    logic [IDX_W-1:0]  dst_eff_W;

    modport master (
        output reg_write_W, mem_to_reg_W, jump_W, read_data_W, alu_out_W,
               pc_plus1_W, write_reg_W, rs_D, rt_D,
        input  rd1_D, rd2_D, result_W, wr_en_eff_W, dst_eff_W
    );

    modport slave (
        input  reg_write_W, mem_to_reg_W, jump_W, read_data_W, alu_out_W,
               pc_plus1_W, write_reg_W, rs_D, rt_D,
        output rd1_D, rd2_D, result_W, wr_en_eff_W, dst_eff_W
    );
endinterface

// File: rtl/writeback_regfile_wb_select.sv
// Write-back value, destination and commit-enable selection; purely combinational, no backpressure.
// A link write (jump) overrides both the load/ALU select and the requested destination.
module writeback_regfile_wb_select
    import writeback_regfile_pkg::*;
#(
    parameter int LINK_REG = DEFAULT_LINK_REG
) (
    input  logic              reg_write,
    input  logic              mem_to_reg,
    input  logic              jump,
    input  logic [DATA_W-1:0] read_data,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] pc_plus1,
    input  logic [IDX_W-1:0]  write_reg,
    output logic [DATA_W-1:0] result,
    output logic [IDX_W-1:0]  dst,
    output logic              wr_en
);
    always_comb begin
        result = alu_out;
        if (jump)
            result = pc_plus1;
        else if (mem_to_reg)
            result = read_data;

        dst   = jump ? IDX_W'(LINK_REG) : write_reg;
        wr_en = (reg_write | jump) && (dst != IDX_W'(REG_ZERO));
    end
endmodule

// File: rtl/writeback_regfile.sv
// Register file with write-through bypass on all read ports and a committed-write counter.
// Writes land one edge after presentation; reads are combinational; never stalls.
module writeback_regfile
    import writeback_regfile_pkg::*;
#(
    parameter int NREGS    = 32,
    parameter int LINK_REG = DEFAULT_LINK_REG
) (
    input  logic                clk,
    input  logic                reset,
    writeback_regfile_if.slave  wb,
    input  logic [IDX_W-1:0]    dbg_addr,
    output logic [DATA_W-1:0]   dbg_data,
    output logic [DATA_W-1:0]   wb_count
);
    logic [DATA_W-1:0] regs [0:NREGS-1];

    writeback_regfile_wb_select #(
        .LINK_REG (LINK_REG)
    ) u_wb_select (
        .reg_write  (wb.reg_write_W),
        .mem_to_reg (wb.mem_to_reg_W),
        .jump       (wb.jump_W),
        .read_data  (wb.read_data_W),
        .alu_out    (wb.alu_out_W),
        .pc_plus1   (wb.pc_plus1_W),
        .write_reg  (wb.write_reg_W),
        .result     (wb.result_W),
        .dst        (wb.dst_eff_W),
        .wr_en      (wb.wr_en_eff_W)
    );

    // Index 0 short-circuits to zero, then the in-flight write wins over the array.
    function automatic logic [DATA_W-1:0] read_port(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(REG_ZERO))
            return '0;
        else if (wb.wr_en_eff_W && (idx == wb.dst_eff_W))
            return wb.result_W;
        else if (int'(idx) < NREGS)
            return regs[idx];
        else
            return '0;
    endfunction

    always_comb begin
        wb.rd1_D = read_port(wb.rs_D);
        wb.rd2_D = read_port(wb.rt_D);
        dbg_data = read_port(dbg_addr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
            wb_count <= '0;
        end else if (wb.wr_en_eff_W) begin
            if (int'(wb.dst_eff_W) < NREGS)
                regs[wb.dst_eff_W] <= wb.result_W;
            wb_count <= wb_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: bypass, select, link, zero register, counter wrap, reset.
module tb_writeback_regfile;
    import writeback_regfile_pkg::*;

    logic              clk;
    logic              reset;
    logic [IDX_W-1:0]  dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic [DATA_W-1:0] wb_count;
    int                n_checks;
    int                n_errors;

    writeback_regfile_if wbif ();

    writeback_regfile dut (
        .clk      (clk),
        .reset    (reset),
        .wb       (wbif.slave),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .wb_count (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wbif.reg_write_W  = 1'b0;
        wbif.mem_to_reg_W = 1'b0;
        wbif.jump_W       = 1'b0;
        wbif.read_data_W  = '0;
        wbif.alu_out_W    = '0;
        wbif.pc_plus1_W   = '0;
        wbif.write_reg_W  = '0;
    endtask

    task automatic alu_write(input logic [4:0] dst, input logic [31:0] val);
        wbif.reg_write_W  = 1'b1;
        wbif.mem_to_reg_W = 1'b0;
        wbif.jump_W       = 1'b0;
        wbif.alu_out_W    = val;
        wbif.write_reg_W  = dst;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        idle();
        wbif.rs_D = 5'd5;
        wbif.rt_D = 5'd7;
        dbg_addr  = 5'd31;
        tick();
        tick();
        check("reset_rd1", wbif.rd1_D, 32'h0);
        check("reset_rd2", wbif.rd2_D, 32'h0);
        check("reset_dbg", dbg_data, 32'h0);
        check("reset_count", wb_count, 32'h0);
        reset = 1'b0;

        // ALU write to r5 with same-cycle bypass, then array read
        alu_write(5'd5, 32'h1234);
        #1;
        check("byp_rd1", wbif.rd1_D, 32'h1234);
        check("wr_en_alu", {31'b0, wbif.wr_en_eff_W}, 32'h1);
        check("dst_alu", {27'b0, wbif.dst_eff_W}, 32'd5);
        tick();
        idle();
        #1;
        check("array_rd1", wbif.rd1_D, 32'h1234);
        check("count_1", wb_count, 32'd1);

        // Load select picks read_data over alu_out
        wbif.reg_write_W  = 1'b1;
        wbif.mem_to_reg_W = 1'b1;
        wbif.read_data_W  = 32'hDEAD_BEEF;
        wbif.alu_out_W    = 32'h1;
        wbif.write_reg_W  = 5'd7;
        #1;
        check("load_result", wbif.result_W, 32'hDEAD_BEEF);
        tick();
        idle();
        dbg_addr = 5'd7;
        #1;
        check("load_r7", dbg_data, 32'hDEAD_BEEF);
        check("load_rd2", wbif.rd2_D, 32'hDEAD_BEEF);

        // Seed r3, then a link write must leave it alone
        alu_write(5'd3, 32'h33);
        tick();
        idle();
        wbif.jump_W      = 1'b1;
        wbif.pc_plus1_W  = 32'h40;
        wbif.write_reg_W = 5'd3;
        wbif.alu_out_W   = 32'h99;
        #1;
        check("link_dst", {27'b0, wbif.dst_eff_W}, 32'd31);
        check("link_wr_en", {31'b0, wbif.wr_en_eff_W}, 32'h1);
        check("link_result", wbif.result_W, 32'h40);
        tick();
        idle();
        dbg_addr = 5'd31;
        #1;
        check("link_r31", dbg_data, 32'h40);
        dbg_addr = 5'd3;
        #1;
        check("link_r3_kept", dbg_data, 32'h33);
        check("count_4", wb_count, 32'd4);

        // Writes to r0 are dropped
        alu_write(5'd0, 32'hFF);
        wbif.rs_D = 5'd0;
        #1;
        check("zero_wr_en", {31'b0, wbif.wr_en_eff_W}, 32'h0);
        check("zero_rd1", wbif.rd1_D, 32'h0);
        tick();
        idle();
        #1;
        check("zero_rd1_after", wbif.rd1_D, 32'h0);
        check("zero_count", wb_count, 32'd4);

        // Dual read of the register being written
        wbif.rs_D = 5'd9;
        wbif.rt_D = 5'd9;
        alu_write(5'd9, 32'hA5);
        #1;
        check("dual_byp_rd1", wbif.rd1_D, 32'hA5);
        check("dual_byp_rd2", wbif.rd2_D, 32'hA5);
        tick();
        alu_write(5'd9, 32'h5A);
        dbg_addr = 5'd9;
        #1;
        check("overwrite_byp_rd1", wbif.rd1_D, 32'h5A);
        check("overwrite_byp_dbg", dbg_data, 32'h5A);
        tick();
        idle();
        #1;
        check("dual_arr_rd1", wbif.rd1_D, 32'h5A);
        check("dual_arr_rd2", wbif.rd2_D, 32'h5A);
        check("count_6", wb_count, 32'd6);

        // Counter wrap
        force dut.wb_count = 32'hFFFF_FFFE;
        #1;
        release dut.wb_count;
        alu_write(5'd10, 32'h1);
        tick();
        check("count_max", wb_count, 32'hFFFF_FFFF);
        tick();
        idle();
        #1;
        check("count_wrap", wb_count, 32'h0);

        // Reset asserted mid-cycle with a write pending
        alu_write(5'd12, 32'hC);
        tick();
        alu_write(5'd9, 32'h77);
        wbif.rs_D = 5'd12;
        wbif.rt_D = 5'd9;
        dbg_addr  = 5'd31;
        #2;
        reset = 1'b1;
        #1;
        check("rst_rd1", wbif.rd1_D, 32'h0);
        check("rst_byp_rd2", wbif.rd2_D, 32'h77);
        check("rst_dbg", dbg_data, 32'h0);
        check("rst_count", wb_count, 32'h0);
        tick();
        reset = 1'b0;
        idle();
        #1;
        check("rst_write_lost", wbif.rd2_D, 32'h0);
        check("rst_count_hold", wb_count, 32'h0);
        alu_write(5'd12, 32'hC0DE);
        tick();
        idle();
        #1;
        check("post_rst_write", wbif.rd1_D, 32'hC0DE);
        check("post_rst_count", wb_count, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 SHALL have parameter NREGS, default 32, meaning the number of architectural registers; register 0 is hardwired to zero.
REQ-002 SHALL have parameter LINK_REG, default 31, meaning the destination of the jump-and-link write.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  asynchronous, active-high; clears all state.
REQ-005 reg_write_W  in  1  write-back enable from MEM/WB.
REQ-006 mem_to_reg_W  in  1  1 = write read_data_W, 0 = write alu_out_W.
REQ-007 jump_W  in  1  link write: value pc_plus1_W, destination LINK_REG.
REQ-008 read_data_W  in  32  load data.
REQ-009 alu_out_W  in  32  ALU result.
REQ-010 pc_plus1_W  in  32  return address for link writes.
REQ-011 write_reg_W  in  5  write-back destination index.
REQ-012 rs_D, rt_D  in  5 each  decode-stage read indices.
REQ-013 rd1_D, rd2_D  out  32 each  decode-stage read data.
REQ-014 result_W  out  32  selected write-back value, for EX forwarding.
REQ-015 wr_en_eff_W  out  1  write actually committed this cycle.
REQ-016 dst_eff_W  out  5  effective destination index.
REQ-017 dbg_addr  in  5  debug read index.
REQ-018 dbg_data  out  32  debug read data.
REQ-019 wb_count  out  32  count of committed writes.

Function
REQ-020 result_W SHALL be: pc_plus1_W if jump_W; else read_data_W if mem_to_reg_W; else alu_out_W. Purely combinational.
REQ-021 dst_eff_W SHALL be LINK_REG if jump_W, else write_reg_W.
REQ-022 wr_en_eff_W SHALL be (reg_write_W OR jump_W) AND dst_eff_W != 0.
REQ-023 On each rising clk edge with wr_en_eff_W=1, register[dst_eff_W] SHALL load result_W; latency of 1 edge; at most one write per cycle.
REQ-024 Writes with dst_eff_W=0 SHALL be dropped; a read of index 0 SHALL always return 0.
REQ-025 rd1_D, rd2_D, dbg_data SHALL be combinational reads of the array.
REQ-026 Write-through bypass: if wr_en_eff_W=1 and the read index equals dst_eff_W (and is nonzero), the read port SHALL return result_W in the same cycle, not the stale array value. This applies independently to rd1_D, rd2_D and dbg_data.
REQ-027 When rs_D=rt_D, both ports SHALL return identical data, including the bypass case.
REQ-028 wb_count SHALL increment by 1 on each edge with wr_en_eff_W=1 and wrap from 0xFFFFFFFF to 0 without a flag.
REQ-029 When jump_W=1, the link write SHALL take priority over write_reg_W and mem_to_reg_W.

Reset
REQ-030 Asserting reset SHALL immediately clear all registers and wb_count to 0, regardless of clk.
REQ-031 While reset is high, no write SHALL commit; read outputs SHALL reflect the cleared array, and the bypass SHALL still follow REQ-026 combinationally.
REQ-032 When reset asserts in the same cycle as a pending write, the write SHALL be lost; after deassertion, the first rising edge SHALL behave normally.

Structure
REQ-033 A shared package SHALL hold REG_ZERO=0, LINK_REG default 31, the data width of 32 and the register index width of 5.
REQ-034 The write-back select (REQ-020 to REQ-022) SHALL be a sub-module wb_select; the array, bypass and counter SHALL live in the top module.

Verification
REQ-035 Reset: pulse reset mid-cycle after writes -> all ports read 0 and wb_count=0 immediately.
REQ-036 Write then read: reg_write_W=1, mem_to_reg_W=0, alu_out_W=0x1234, write_reg_W=5, rs_D=5 -> rd1_D=0x1234 the same cycle (bypass); after the edge with reg_write_W=0, rd1_D=0x1234 from the array; wb_count=1.
REQ-037 Load select: mem_to_reg_W=1, read_data_W=0xDEADBEEF, alu_out_W=0x1, write_reg_W=7 -> register 7 = 0xDEADBEEF.
REQ-038 Link: jump_W=1, pc_plus1_W=0x40, write_reg_W=3, reg_write_W=0 -> register 31 = 0x40; register 3 unchanged; dst_eff_W=31.
REQ-039 Zero register: reg_write_W=1, write_reg_W=0, alu_out_W=0xFF -> wr_en_eff_W=0; rd of index 0 = 0; wb_count unchanged.
REQ-040 Dual read and wrap: rs_D=rt_D=9 during a write of 0xA5 to register 9 -> rd1_D=rd2_D=0xA5; wb_count forced near 0xFFFFFFFF plus one write -> wb_count=0.
